// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer and its 1-bit slice.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ADD and SLT both go through the adder path and thread the carry.
  function automatic logic op_is_arith(input logic [1:0] op);
    return op[1];
  endfunction

endpackage : alu_pkg

// File: rtl/alu_bit_comb.sv
// Combinational 1-bit ALU slice: AND / OR / full-add selected by op.
module alu_bit_comb
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       r,
  output logic       cout
);

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
    endcase
  end

endmodule : alu_bit_comb

// File: rtl/alu_serial_seq.sv
// Word-level ALU built from one 1-bit slice, iterating LSB-first one bit per clock.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  input  logic             req_binv,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_carry,
  output logic             resp_ovf
);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] result_reg;

  logic             bit_r;
  logic             bit_cout;
  logic             is_last;
  logic             ovf_next;
  logic             slt_bit;
  logic [WIDTH-1:0] result_ins;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] b_cap;
  logic             carry_init;

  assign req_ready = (state_reg == S_IDLE);

  // SLT is a subtract, so it inverts B and seeds the carry just like SUB.
  assign b_cap      = (req_binv || req_op == OP_SLT) ? ~req_b : req_b;
  assign carry_init = (req_op == OP_ADD && req_binv) || (req_op == OP_SLT);

  alu_bit_comb u_bit (
    .a    (a_reg[cnt_reg]),
    .b    (b_reg[cnt_reg]),
    .cin  (carry_reg),
    .op   (op_reg),
    .r    (bit_r),
    .cout (bit_cout)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ins
      assign result_ins[gi] = (cnt_reg == CNT_W'(gi)) ? bit_r : result_reg[gi];
    end
  endgenerate

  assign is_last  = (cnt_reg == CNT_W'(WIDTH - 1));
  // Carry into the MSB is still in carry_reg while the MSB is being evaluated.
  assign ovf_next = carry_reg ^ bit_cout;
  assign slt_bit  = bit_r ^ ovf_next;
  assign result_next = (op_reg == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : result_ins;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      carry_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= OP_AND;
      result_reg  <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_carry  <= 1'b0;
      resp_ovf    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            a_reg      <= req_a;
            b_reg      <= b_cap;
            op_reg     <= req_op;
            carry_reg  <= carry_init;
            cnt_reg    <= '0;
            result_reg <= '0;
            state_reg  <= S_RUN;
          end
        end
        S_RUN: begin
          result_reg <= result_ins;
          if (op_is_arith(op_reg)) carry_reg <= bit_cout;
          if (is_last) begin
            result_reg  <= result_next;
            resp_result <= result_next;
            resp_zero   <= (result_next == '0);
            resp_carry  <= op_is_arith(op_reg) ? bit_cout : 1'b0;
            resp_ovf    <= (op_reg == OP_ADD) ? ovf_next : 1'b0;
            resp_valid  <= 1'b1;
            state_reg   <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_reg  <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule : alu_serial_seq

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [1:0]   req_op;
  logic         req_binv;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_result;
  logic         resp_zero;
  logic         resp_carry;
  logic         resp_ovf;

  int checks = 0;
  int errors = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_binv    (req_binv),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_carry  (resp_carry),
    .resp_ovf    (resp_ovf)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request and hold it until the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic binv);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_before_send", 32'(req_ready), 32'd1);
    req_a = a; req_b = b; req_op = op; req_binv = binv; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("req_ready_after_accept", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_resp();
    int cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!resp_valid && cyc < 20);
    check("latency", 32'(cyc), 32'(W));
  endtask

  task automatic check_resp(input string name, input logic [W-1:0] res,
                            input logic z, input logic c, input logic v);
    $display("%s: result=0x%02h zero=%0b carry=%0b ovf=%0b", name, resp_result,
             resp_zero, resp_carry, resp_ovf);
    check({name, "_result"}, 32'(resp_result), 32'(res));
    check({name, "_zero"},   32'(resp_zero),   32'(z));
    check({name, "_carry"},  32'(resp_carry),  32'(c));
    check({name, "_ovf"},    32'(resp_ovf),    32'(v));
  endtask

  task automatic drain(input logic [W-1:0] res);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("drain_valid_low", 32'(resp_valid), 32'd0);
    check("drain_ready_high", 32'(req_ready), 32'd1);
    check("drain_result_held", 32'(resp_result), 32'(res));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic binv, input logic [W-1:0] res,
                        input logic z, input logic c, input logic v);
    send(a, b, op, binv);
    wait_resp();
    check_resp(name, res, z, c, v);
    drain(res);
  endtask

  initial begin
    logic [W-1:0] held;
    reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 2'b00;
    req_binv = 1'b0; resp_ready = 1'b0;
    tick(); tick();
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_result", 32'(resp_result), 32'd0);
    reset_n = 1'b1;
    tick();

    run_op("add_7f_01",  8'h7F, 8'h01, 2'b10, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op("sub_05_05",  8'h05, 8'h05, 2'b10, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("slt_80_01",  8'h80, 8'h01, 2'b11, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
    run_op("slt_7f_80",  8'h7F, 8'h80, 2'b11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // AND with B inverted, then hold DONE under backpressure with a pending request.
    send(8'hF0, 8'h3C, 2'b00, 1'b1);
    wait_resp();
    check_resp("and_binv", 8'hC0, 1'b0, 1'b0, 1'b0);
    req_a = 8'hF0; req_b = 8'h0F; req_op = 2'b01; req_binv = 1'b0; req_valid = 1'b1;
    held = resp_result;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_result_stable", 32'(resp_result), 32'(held));
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_release_idle", 32'(req_ready), 32'd1);
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    check("bp_new_accept", 32'(req_ready), 32'd0);
    wait_resp();
    check_resp("or_after_bp", 8'hFF, 1'b0, 1'b0, 1'b0);
    drain(8'hFF);

    // Abort mid-RUN at bit 3.
    send(8'h12, 8'h34, 2'b10, 1'b0);
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    $display("reset_mid_run: req_ready=%0b resp_valid=%0b result=0x%02h", req_ready,
             resp_valid, resp_result);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_result", 32'(resp_result), 32'd0);
    check("rst_flags", {29'd0, resp_zero, resp_carry, resp_ovf}, 32'd0);
    tick();
    check("rst_no_response", 32'(resp_valid), 32'd0);

    run_op("add_01_01", 8'h01, 8'h01, 2'b10, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_serial_seq
